// File: rtl/nn_window_feeder.sv
// Turns a one-pixel-per-beat raster stream into 2x2 stride-1 windows for the conv neurons.
// A single line buffer holds the previous row; it is read and then overwritten in the same accept.
module nn_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_pixel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3:0][7:0] pixels,
    output logic            win_valid,
    output logic [4:0]      win_col,
    output logic [4:0]      win_row,
    output logic            frame_done,
    output logic            busy
);

    localparam int CW = $clog2(IMG_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   col;
    logic [4:0]      row;
    logic [7:0]      linebuf [IMG_W];
    logic [7:0]      left_cur;
    logic [7:0]      left_above;
    logic [7:0]      above;
    logic            accept;
    logic            last_col;
    logic            last_row;

    // in_ready tracks the state one-for-one, so it doubles as the accept qualifier
    assign accept   = in_valid && in_ready;
    assign above    = linebuf[col];
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == 5'(IMG_H - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (accept && last_col) state_next = STREAM;
            STREAM:  if (accept && last_col && last_row) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            left_cur   <= '0;
            left_above <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            pixels     <= '0;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready   <= (state_next != IDLE);
            busy       <= (state_next != IDLE);
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col <= '0;
                        row <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        left_cur <= in_pixel;
                        if (last_col) begin
                            col <= '0;
                            row <= 5'd1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        left_cur   <= in_pixel;
                        left_above <= above;
                        // column 0 only primes the left-hand registers
                        if (col != '0) begin
                            pixels     <= {in_pixel, left_cur, above, left_above};
                            win_valid  <= 1'b1;
                            win_col    <= 5'(col);
                            win_row    <= row;
                            frame_done <= last_col && last_row;
                        end
                        if (last_col) begin
                            col <= '0;
                            row <= row + 5'd1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer is intentionally not reset; row 0 of every frame rewrites it before use
    always_ff @(posedge clk) begin
        if (accept) linebuf[col] <= in_pixel;
    end

endmodule

// File: tb/tb_nn_window_feeder.sv
// Directed bench for nn_window_feeder on a 4x4 frame: reset, basic, bubbles, stray start,
// back-to-back frames and mid-frame abort.
module tb_nn_window_feeder;

    localparam int W = 4;
    localparam int H = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      in_pixel = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0][7:0] pixels;
    logic            win_valid;
    logic [4:0]      win_col;
    logic [4:0]      win_row;
    logic            frame_done;
    logic            busy;

    int          compared = 0;
    int          mismatched = 0;
    int          nwin;
    logic [31:0] first_win;
    logic [31:0] last_win;

    nn_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .pixels(pixels), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input bit inv, input int r, input int c);
        logic [7:0] v;
        v = 8'(r * 16 + c);
        return inv ? 8'hFF - v : v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] px, input bit v, output bit acc);
        bit rdy;
        in_pixel = px;
        in_valid = v;
        rdy = in_ready;
        step();
        acc = v && rdy;
        in_valid = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Feeds the first n pixels of a frame; start_at >= 0 pulses start with that pixel
    task automatic run_pixels(input bit inv, input int n, input int bubble_pct, input int start_at);
        nwin = 0;
        for (int i = 0; i < n; i++) begin
            int r = i / W;
            int c = i % W;
            bit acc;
            for (int b = 0; b < 3 && $urandom_range(0, 99) < bubble_pct; b++) begin
                beat(8'hA5, 1'b0, acc);
                chk("bubble_no_win", win_valid, 0);
            end
            if (i == start_at) start = 1'b1;
            beat(pix(inv, r, c), 1'b1, acc);
            start = 1'b0;
            chk("accepted", acc, 1);
            if (r >= 1 && c >= 1) begin
                logic [31:0] e;
                e = {pix(inv, r, c), pix(inv, r, c - 1), pix(inv, r - 1, c), pix(inv, r - 1, c - 1)};
                chk("win_valid", win_valid, 1);
                chk("pixels", pixels, e);
                chk("win_col", win_col, c);
                chk("win_row", win_row, r);
                chk("frame_done", frame_done, (i == W * H - 1) ? 1 : 0);
                if (nwin == 0) first_win = pixels;
                last_win = pixels;
                nwin++;
            end else begin
                chk("no_win", win_valid, 0);
                chk("no_frame_done", frame_done, 0);
            end
        end
    endtask

    initial begin
        // reset dominates start and in_valid
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_pixel = 8'h77;
        step();
        step();
        check_idle_outputs("reset");
        chk("reset_pixels", pixels, 0);
        chk("reset_win_col", win_col, 0);
        chk("reset_win_row", win_row, 0);
        rst = 1'b0; start = 1'b0;
        step();
        step();
        check_idle_outputs("idle_ignores_valid");
        in_valid = 1'b0;

        // basic frame
        do_start();
        run_pixels(1'b0, W * H, 0, -1);
        chk("basic_count", nwin, 9);
        chk("basic_first", first_win, 32'h11100100);
        chk("basic_last", last_win, 32'h33322322);
        step();
        check_idle_outputs("after_frame");

        // random bubbles
        do_start();
        run_pixels(1'b0, W * H, 40, -1);
        chk("bubble_count", nwin, 9);
        chk("bubble_first", first_win, 32'h11100100);
        chk("bubble_last", last_win, 32'h33322322);
        step();

        // start during STREAM is ignored
        do_start();
        run_pixels(1'b0, W * H, 0, 9);
        chk("stray_start_count", nwin, 9);
        chk("stray_start_last", last_win, 32'h33322322);

        // back-to-back: start in the frame_done cycle
        chk("b2b_ready_low", in_ready, 0);
        chk("b2b_frame_done", frame_done, 1);
        do_start();
        run_pixels(1'b1, W * H, 0, -1);
        chk("inv_count", nwin, 9);
        chk("inv_first", first_win, 32'hEEEFFEFF);
        chk("inv_last", last_win, 32'hCCCDDCDD);

        // abort after 7 accepts
        do_start();
        run_pixels(1'b1, 7, 0, -1);
        chk("abort_partial_count", nwin, 2);
        rst = 1'b1;
        step();
        check_idle_outputs("abort");
        rst = 1'b0;
        step();
        chk("abort_idle_ready", in_ready, 0);

        do_start();
        run_pixels(1'b0, W * H, 0, -1);
        chk("rerun_count", nwin, 9);
        chk("rerun_first", first_win, 32'h11100100);
        chk("rerun_last", last_win, 32'h33322322);
        step();
        check_idle_outputs("rerun_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
